// File: rtl/byte_reg_write_arbiter.sv
// Round-robin arbiter sharing one enable-loaded byte register among NUM_REQ requesters.
// Each grant runs IDLE -> WRITE (load pulse) -> ACK (ack pulse) -> RELEASE (wait for request drop).
module byte_reg_write_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int IDX_W   = 2
) (
    input  logic                 Reset_n_i,
    input  logic                 Clk_i,
    input  logic                 Enable_i,
    input  logic [NUM_REQ-1:0]   Req_i,
    input  logic [8*NUM_REQ-1:0] Data_i,
    output logic [NUM_REQ-1:0]   Ack_o,
    output logic [7:0]           RegD_o,
    output logic                 RegEnable_o,
    output logic                 Busy_o,
    output logic [IDX_W-1:0]     Owner_o
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        WRITE   = 2'd1,
        ACK     = 2'd2,
        RELEASE = 2'd3
    } state_t;

    state_t               r_state, w_state_nxt;
    logic [IDX_W-1:0]     r_ptr, w_ptr_nxt;
    logic [IDX_W-1:0]     r_owner, w_owner_nxt;
    logic [7:0]           r_regd, w_regd_nxt;
    logic                 r_regen, w_regen_nxt;
    logic [NUM_REQ-1:0]   r_ack, w_ack_nxt;
    logic                 r_busy, w_busy_nxt;

    logic                 w_found;
    logic [IDX_W-1:0]     w_win;

    // First requester at or after the pointer, wrapping modulo NUM_REQ.
    always_comb begin
        w_found = 1'b0;
        w_win   = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (!w_found && Req_i[(int'(r_ptr) + i) % NUM_REQ]) begin
                w_found = 1'b1;
                w_win   = IDX_W'((int'(r_ptr) + i) % NUM_REQ);
            end
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_ptr_nxt   = r_ptr;
        w_owner_nxt = r_owner;
        w_regd_nxt  = r_regd;
        w_regen_nxt = 1'b0;
        w_ack_nxt   = '0;
        w_busy_nxt  = r_busy;
        case (r_state)
            IDLE: begin
                if (Enable_i && w_found) begin
                    w_owner_nxt = w_win;
                    w_regd_nxt  = Data_i[8*int'(w_win) +: 8];
                    w_regen_nxt = 1'b1;
                    w_busy_nxt  = 1'b1;
                    w_state_nxt = WRITE;
                end
            end
            WRITE: begin
                w_ack_nxt   = NUM_REQ'(1) << r_owner;
                w_state_nxt = ACK;
            end
            ACK: begin
                w_ptr_nxt   = (r_owner == IDX_W'(NUM_REQ-1)) ? '0 : r_owner + 1'b1;
                w_state_nxt = RELEASE;
            end
            RELEASE: begin
                // Only the current owner's request matters until we are back in IDLE.
                if (!Req_i[r_owner]) begin
                    w_busy_nxt  = 1'b0;
                    w_state_nxt = IDLE;
                end
            end
            default: begin
                w_busy_nxt  = 1'b0;
                w_state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge Clk_i or negedge Reset_n_i) begin
        if (!Reset_n_i) begin
            r_state <= IDLE;
            r_ptr   <= '0;
            r_owner <= '0;
            r_regd  <= 8'h00;
            r_regen <= 1'b0;
            r_ack   <= '0;
            r_busy  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_ptr   <= w_ptr_nxt;
            r_owner <= w_owner_nxt;
            r_regd  <= w_regd_nxt;
            r_regen <= w_regen_nxt;
            r_ack   <= w_ack_nxt;
            r_busy  <= w_busy_nxt;
        end
    end

    assign Ack_o       = r_ack;
    assign RegD_o      = r_regd;
    assign RegEnable_o = r_regen;
    assign Busy_o      = r_busy;
    assign Owner_o     = r_owner;

endmodule

// File: tb/tb_byte_reg_write_arbiter.sv
// Directed bench for byte_reg_write_arbiter: cycle-by-cycle vector table plus
// hand sequences for reset, full rotation, enable gating and reset mid-write.
module tb_byte_reg_write_arbiter;

    logic        Reset_n_i;
    logic        Clk_i;
    logic        Enable_i;
    logic [3:0]  Req_i;
    logic [31:0] Data_i;
    logic [3:0]  Ack_o;
    logic [7:0]  RegD_o;
    logic        RegEnable_o;
    logic        Busy_o;
    logic [1:0]  Owner_o;

    int n_chk;
    int n_err;

    byte_reg_write_arbiter #(.NUM_REQ(4), .IDX_W(2)) dut (
        .Reset_n_i   (Reset_n_i),
        .Clk_i       (Clk_i),
        .Enable_i    (Enable_i),
        .Req_i       (Req_i),
        .Data_i      (Data_i),
        .Ack_o       (Ack_o),
        .RegD_o      (RegD_o),
        .RegEnable_o (RegEnable_o),
        .Busy_o      (Busy_o),
        .Owner_o     (Owner_o)
    );

    initial Clk_i = 1'b0;
    always #5 Clk_i = ~Clk_i;

    typedef struct {
        logic [3:0]  req;
        logic        en;
        logic [31:0] data;
        logic        x_regen;
        logic [7:0]  x_regd;
        logic [3:0]  x_ack;
        logic        x_busy;
        logic [1:0]  x_owner;
    } vec_t;

    vec_t vecs[22];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s got %0h want %0h", nm, act, exp);
        end
    endtask

    task automatic chk_all(input string tag, input logic regen, input logic [7:0] regd,
                           input logic [3:0] ack, input logic busy, input logic [1:0] owner);
        chk({tag, ".regen"}, 32'(RegEnable_o), 32'(regen));
        chk({tag, ".regd"},  32'(RegD_o),      32'(regd));
        chk({tag, ".ack"},   32'(Ack_o),       32'(ack));
        chk({tag, ".busy"},  32'(Busy_o),      32'(busy));
        chk({tag, ".owner"}, 32'(Owner_o),     32'(owner));
    endtask

    task automatic step();
        @(posedge Clk_i);
        #1;
    endtask

    initial begin
        logic [3:0] remaining;
        logic [7:0] dbyte;
        n_chk = 0;
        n_err = 0;

        // Single write by 2 with Data_i changing after grant and Enable_i low mid-write,
        // then 3 beats 0 from P=3, keep-high in RELEASE, and early request drop.
        vecs[0]  = '{4'b0100, 1'b1, 32'h44A52211, 1'b1, 8'hA5, 4'b0000, 1'b1, 2'd2};
        vecs[1]  = '{4'b0100, 1'b0, 32'h44FF2211, 1'b0, 8'hA5, 4'b0100, 1'b1, 2'd2};
        vecs[2]  = '{4'b0000, 1'b0, 32'h44FF2211, 1'b0, 8'hA5, 4'b0000, 1'b1, 2'd2};
        vecs[3]  = '{4'b0000, 1'b1, 32'h44FF2211, 1'b0, 8'hA5, 4'b0000, 1'b0, 2'd2};
        vecs[4]  = '{4'b1001, 1'b1, 32'h44FF2211, 1'b1, 8'h44, 4'b0000, 1'b1, 2'd3};
        vecs[5]  = '{4'b1001, 1'b1, 32'h44FF2211, 1'b0, 8'h44, 4'b1000, 1'b1, 2'd3};
        vecs[6]  = '{4'b0001, 1'b1, 32'h44FF2211, 1'b0, 8'h44, 4'b0000, 1'b1, 2'd3};
        vecs[7]  = '{4'b0001, 1'b1, 32'h44FF2211, 1'b0, 8'h44, 4'b0000, 1'b0, 2'd3};
        vecs[8]  = '{4'b0001, 1'b1, 32'h44FF2211, 1'b1, 8'h11, 4'b0000, 1'b1, 2'd0};
        vecs[9]  = '{4'b0001, 1'b1, 32'h44FF2211, 1'b0, 8'h11, 4'b0001, 1'b1, 2'd0};
        vecs[10] = '{4'b0000, 1'b1, 32'h44FF2211, 1'b0, 8'h11, 4'b0000, 1'b1, 2'd0};
        vecs[11] = '{4'b0000, 1'b1, 32'h44FF2211, 1'b0, 8'h11, 4'b0000, 1'b0, 2'd0};
        vecs[12] = '{4'b0010, 1'b1, 32'h44FF2211, 1'b1, 8'h22, 4'b0000, 1'b1, 2'd1};
        vecs[13] = '{4'b0010, 1'b1, 32'h44FF2211, 1'b0, 8'h22, 4'b0010, 1'b1, 2'd1};
        vecs[14] = '{4'b0010, 1'b1, 32'h44FF2211, 1'b0, 8'h22, 4'b0000, 1'b1, 2'd1};
        vecs[15] = '{4'b0110, 1'b1, 32'h44FF2211, 1'b0, 8'h22, 4'b0000, 1'b1, 2'd1};
        vecs[16] = '{4'b0110, 1'b1, 32'h44FF2211, 1'b0, 8'h22, 4'b0000, 1'b1, 2'd1};
        vecs[17] = '{4'b0100, 1'b1, 32'h44FF2211, 1'b0, 8'h22, 4'b0000, 1'b0, 2'd1};
        vecs[18] = '{4'b0100, 1'b1, 32'h44FF2211, 1'b1, 8'hFF, 4'b0000, 1'b1, 2'd2};
        vecs[19] = '{4'b0000, 1'b1, 32'h44FF2211, 1'b0, 8'hFF, 4'b0100, 1'b1, 2'd2};
        vecs[20] = '{4'b0000, 1'b1, 32'h44FF2211, 1'b0, 8'hFF, 4'b0000, 1'b1, 2'd2};
        vecs[21] = '{4'b0000, 1'b1, 32'h44FF2211, 1'b0, 8'hFF, 4'b0000, 1'b0, 2'd2};

        // Reset with every request high: nothing moves.
        Reset_n_i = 1'b0;
        Enable_i  = 1'b1;
        Req_i     = 4'hF;
        Data_i    = 32'h44332211;
        step();
        step();
        chk_all("rst", 1'b0, 8'h00, 4'b0000, 1'b0, 2'd0);
        Reset_n_i = 1'b1;
        step();
        chk_all("rst_first", 1'b1, 8'h11, 4'b0000, 1'b1, 2'd0);
        Req_i = 4'h0;
        step();
        chk("rst_first.ack", 32'(Ack_o), 32'h1);
        step();
        step();
        chk("rst_first.idle", 32'(Busy_o), 32'h0);

        for (int i = 0; i < 22; i++) begin
            Req_i    = vecs[i].req;
            Enable_i = vecs[i].en;
            Data_i   = vecs[i].data;
            step();
            chk_all($sformatf("vec%0d", i), vecs[i].x_regen, vecs[i].x_regd,
                    vecs[i].x_ack, vecs[i].x_busy, vecs[i].x_owner);
        end

        // Fresh reset, all four requesting: grants 0,1,2,3 back to back, 4 cycles each.
        Req_i     = 4'h0;
        Reset_n_i = 1'b0;
        step();
        Reset_n_i = 1'b1;
        Data_i    = 32'hD4C3B2A1;
        remaining = 4'hF;
        for (int k = 0; k < 4; k++) begin
            Req_i = remaining;
            dbyte = 8'hA1 + 8'(k * 8'h11);
            step();
            chk_all($sformatf("rr%0d.grant", k), 1'b1, dbyte, 4'b0000, 1'b1, 2'(k));
            step();
            chk($sformatf("rr%0d.ack", k), 32'(Ack_o), 32'(4'b0001 << k));
            remaining = remaining & ~(4'b0001 << k);
            Req_i = remaining;
            step();
            chk($sformatf("rr%0d.ack_clr", k), 32'(Ack_o), 32'h0);
            step();
            chk($sformatf("rr%0d.idle", k), 32'(Busy_o), 32'h0);
        end

        // Enable low blocks grants in IDLE; the grant lands on the edge after it rises.
        Enable_i = 1'b0;
        Req_i    = 4'b0010;
        for (int c = 0; c < 10; c++) begin
            step();
            chk($sformatf("en_off%0d.regen", c), 32'(RegEnable_o), 32'h0);
            chk($sformatf("en_off%0d.busy", c),  32'(Busy_o),      32'h0);
        end
        Enable_i = 1'b1;
        step();
        chk_all("en_on", 1'b1, 8'hB2, 4'b0000, 1'b1, 2'd1);
        step();
        Req_i = 4'b0000;
        step();
        step();
        chk("en_on.idle", 32'(Busy_o), 32'h0);

        // Reset during WRITE: outputs clear at once, no Ack, and P returns to 0.
        Req_i = 4'b0100;
        step();
        chk("mid.regen", 32'(RegEnable_o), 32'h1);
        #2;
        Reset_n_i = 1'b0;
        #1;
        chk_all("mid.rst", 1'b0, 8'h00, 4'b0000, 1'b0, 2'd0);
        Req_i = 4'b0101;
        for (int c = 0; c < 3; c++) begin
            step();
            chk($sformatf("mid.noack%0d", c), 32'(Ack_o), 32'h0);
        end
        Reset_n_i = 1'b1;
        step();
        chk_all("mid.p0", 1'b1, 8'hA1, 4'b0000, 1'b1, 2'd0);

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule
